// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with a one-deep pending buffer.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    typedef enum logic {ON, BLANK} phase_t;

    localparam logic [15:0] ON_LAST    = 16'(CLK_DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    phase_t      phase, phase_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [15:0] disp, pend;
    logic        pend_full;
    logic [3:0]  nib;
    logic        lead_zero;
    logic        boundary;
    logic        xfer;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt + 16'd1;
        idx_nxt   = idx;
        case (phase)
            ON: begin
                if (cnt == ON_LAST) begin
                    phase_nxt = BLANK;
                    cnt_nxt   = 16'd0;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    phase_nxt = ON;
                    cnt_nxt   = 16'd0;
                    idx_nxt   = idx + 2'd1;
                end
            end
            default: begin
                phase_nxt = ON;
                cnt_nxt   = 16'd0;
            end
        endcase

        boundary = (phase == BLANK) && (idx == 2'd3) && (cnt == BLANK_LAST);
        nib      = disp[{idx, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
        // A digit is a leading zero when it and every digit to its left are zero.
        case (idx)
            2'd3:    lead_zero = (disp[15:12] == 4'd0);
            2'd2:    lead_zero = (disp[15:8]  == 8'd0);
            2'd1:    lead_zero = (disp[15:4]  == 12'd0);
            default: lead_zero = 1'b0;
        endcase
`else
        lead_zero = 1'b0;
`endif

        // Outputs are forced off combinationally for the whole time reset is held.
        an  = 4'b0000;
        seg = 7'b0000000;
        if (rst_n && (phase == ON) && !lead_zero) begin
            an  = 4'b0001 << idx;
            seg = decode(nib);
        end
        in_ready   = rst_n & ~pend_full;
        xfer       = in_valid & in_ready;
        frame_done = rst_n & boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase     <= ON;
            cnt       <= 16'd0;
            idx       <= 2'd0;
            disp      <= 16'h0000;
            pend      <= 16'h0000;
            pend_full <= 1'b0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            // in_ready is low whenever pending is full, so a boundary load and a transfer never coincide.
            if (boundary && pend_full) begin
                disp      <= pend;
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend      <= in_data;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4: ON-phase length per digit in clk cycles; legal range 1..65535.
REQ-002 Parameter BLANK_CYCLES, default 2: all-digits-off gap after each digit in cycles; legal range 1..255.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 in_valid  input  1: in_data offered this cycle.
REQ-006 in_data  input  16: four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 in_ready  output  1: pending buffer can accept in_data.
REQ-008 seg  output  7: segment drive, bit 0 = a ... bit 6 = g, active-high.
REQ-009 an  output  4: one-hot digit enable, active-high; bit i enables digit i.
REQ-010 frame_done  output  1: single-cycle pulse at each frame boundary.

Function
REQ-011 The block SHALL contain a 16-bit display register, a 16-bit pending register with a full flag, a 2-bit digit index, a phase FSM {ON, BLANK} and a phase counter.
REQ-012 Slot i: ON for CLK_DIV cycles (an = one-hot(i), seg = decode(digit i)), then BLANK for BLANK_CYCLES cycles (an = 4'b0000, seg = 7'b0000000).
REQ-013 ON->BLANK when the counter reaches CLK_DIV-1; BLANK->ON when it reaches BLANK_CYCLES-1. The counter SHALL clear on every phase change. The index SHALL increment on BLANK->ON and wrap from 3 to 0.
REQ-014 Frame period SHALL be exactly 4*(CLK_DIV+BLANK_CYCLES) cycles, with no idle cycles.
REQ-015 Outputs an and seg SHALL never enable two digits in one cycle and SHALL never change digit without at least BLANK_CYCLES cycles of an = 0 in between.
REQ-016 decode SHALL be the standard active-high BCD-to-7-segment mapping for 0..9. Nibbles 10..15 SHALL display a dash, seg = 7'b1000000.
REQ-017 in_ready SHALL equal NOT(pending full) and SHALL be 0 while rst_n = 0. A transfer occurs when in_valid and in_ready are both 1; it sets pending full.
REQ-018 Frame boundary is the last BLANK cycle of slot 3. frame_done SHALL be 1 in exactly that cycle.
REQ-019 At the frame boundary, if pending is full, the display register SHALL load the pending register and pending SHALL become empty. The new value SHALL be shown from the next cycle (digit 0 ON). Displayed values SHALL never change mid-frame.
REQ-020 Transfer in the boundary cycle with pending empty: the data SHALL land in pending and be displayed at the following boundary.
REQ-021 in_data without a transfer SHALL be ignored. in_valid held high with in_ready = 0 SHALL cause no state change.

Reset
REQ-022 While rst_n = 0 at a clock edge, the block SHALL set: display = 16'h0000, pending = 16'h0000, pending empty, index = 0, phase = ON, counter = 0.
REQ-023 Reset value of every output: an = 4'b0000, seg = 7'b0000000, in_ready = 0, frame_done = 0, held for as long as rst_n = 0.
REQ-024 In the first cycle after rst_n goes high: an = 4'b0001, seg = decode(0) = 7'b0111111, in_ready = 1.
REQ-025 Reset asserted mid-frame or with pending full SHALL discard all state, with no partial update.

Configuration
REQ-026 Macro SEG_SCAN_LZB_EN SHALL enable leading-zero blanking.
REQ-027 With SEG_SCAN_LZB_EN defined, a digit i in 3..1 whose nibble and all higher nibbles are 0 SHALL be blanked during its ON phase (an = 0, seg = 0) with unchanged slot timing. Digit 0 SHALL never be blanked.
REQ-028 Without SEG_SCAN_LZB_EN, all four digits SHALL always be driven.

Verification (CLK_DIV=4, BLANK_CYCLES=2, frame = 24 cycles)
REQ-029 Reset release, no input -> an sequence 0001 x4, 0000 x2, 0010 x4, 0000 x2, ... ; seg = 7'b0111111 while an != 0; frame_done at cycles 23, 47, ...
REQ-030 Transfer 16'h1234 at cycle 5 -> in_ready = 0 from cycle 6; display shows 0000 until cycle 23; from cycle 24 digit 0 seg = 7'b1100110 ("4"); in_ready = 1 at cycle 24.
REQ-031 Second transfer offered while pending full -> in_ready = 0, no transfer; the first value is displayed at the next boundary; the second is accepted afterwards.
REQ-032 Transfer 16'h00AF in the boundary cycle (pending empty) -> shown one frame later; digits 1 and 0 seg = 7'b1000000.
REQ-033 rst_n low for 1 cycle mid-slot-2 with pending full -> an = 0 and in_ready = 0 in that cycle, then the REQ-024 state; the pending value is never displayed.
REQ-034 SEG_SCAN_LZB_EN defined, display 16'h0050 -> digits 3 and 2 an = 0 throughout; digit 1 "5"; digit 0 "0"; frame period still 24 cycles.
